// File: rtl/parking_pkg.sv
// Shared types and default timing for the car-park gate controller.
package parking_pkg;

  localparam int unsigned DEF_COUNT_W      = 11;
  localparam int unsigned DEF_OPEN_TIMEOUT = 20;
  localparam int unsigned DEF_DENY_CYCLES  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPEN = 2'd1,
    DENY = 2'd2
  } gate_state_t;

  // Per-gate event/drive bundle produced by one gate FSM.
  typedef struct packed {
    logic pulse_std;
    logic pulse_uni;
    logic open;
    logic deny;
    logic timeout;
  } gate_out_t;

endpackage

// File: rtl/parking_gate_controller_if.sv
// Sensor / Parking-side signal bundle for the gate controller.
//   slave  : controller view (sensors and Parking flags in, pulses and drives out)
//   master : environment view (opposite directions)
interface parking_gate_controller_if #(
  parameter int unsigned COUNT_W = parking_pkg::DEF_COUNT_W
);
  logic               arrive;
  logic               arrive_uni;
  logic               pass_in;
  logic               leave;
  logic               leave_uni;
  logic               pass_out;
  logic               ivs;
  logic               uivs;
  logic [COUNT_W-1:0] pc;
  logic [COUNT_W-1:0] upc;
  logic               ci;
  logic               uci;
  logic               ce;
  logic               uce;
  logic               gate_in_open;
  logic               gate_out_open;
  logic               deny_in;
  logic               deny_out;
  logic               timeout_in;
  logic               timeout_out;

  modport slave (
    input  arrive, arrive_uni, pass_in, leave, leave_uni, pass_out,
    input  ivs, uivs, pc, upc,
    output ci, uci, ce, uce, gate_in_open, gate_out_open,
    output deny_in, deny_out, timeout_in, timeout_out
  );

  modport master (
    output arrive, arrive_uni, pass_in, leave, leave_uni, pass_out,
    output ivs, uivs, pc, upc,
    input  ci, uci, ce, uce, gate_in_open, gate_out_open,
    input  deny_in, deny_out, timeout_in, timeout_out
  );
endinterface

// File: rtl/parking_gate_fsm.sv
// One barrier: IDLE -> OPEN (granted) or DENY (refused), one event pulse per OPEN visit.
//   req/req_uni      : car waiting and its type
//   grant_std/uni    : admission term for each car type
//   pass             : beam broken while open
//   pulse_std/uni    : one-cycle count event for the latched type
//   open/deny        : barrier drive / denial indication
//   timeout          : one-cycle pulse when the gate closes without a pass
module parking_gate_fsm
  import parking_pkg::*;
#(
  parameter int unsigned OPEN_TIMEOUT = DEF_OPEN_TIMEOUT,
  parameter int unsigned DENY_CYCLES  = DEF_DENY_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic req_uni,
  input  logic grant_std,
  input  logic grant_uni,
  input  logic pass,
  output logic pulse_std,
  output logic pulse_uni,
  output logic open,
  output logic deny,
  output logic timeout
);

  localparam int unsigned MAX_CYC = (OPEN_TIMEOUT > DENY_CYCLES) ? OPEN_TIMEOUT : DENY_CYCLES;
  localparam int unsigned TIMER_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [TIMER_W-1:0] OPEN_LAST = TIMER_W'(OPEN_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] DENY_LAST = TIMER_W'(DENY_CYCLES - 1);

  gate_state_t        state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               uni_q, uni_d;
  logic               pulse_std_d, pulse_uni_d, open_d, deny_d, timeout_d;
  logic               granted_c;

  // State, timer, latched car type and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      uni_q     <= 1'b0;
      pulse_std <= 1'b0;
      pulse_uni <= 1'b0;
      open      <= 1'b0;
      deny      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      uni_q     <= uni_d;
      pulse_std <= pulse_std_d;
      pulse_uni <= pulse_uni_d;
      open      <= open_d;
      deny      <= deny_d;
      timeout   <= timeout_d;
    end
  end

  assign granted_c = req_uni ? grant_uni : grant_std;

  // Next state and next output values; outputs describe the state being entered.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    uni_d       = uni_q;
    pulse_std_d = 1'b0;
    pulse_uni_d = 1'b0;
    open_d      = 1'b0;
    deny_d      = 1'b0;
    timeout_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          timer_d = '0;
          if (granted_c) begin
            state_d = OPEN;
            uni_d   = req_uni;
            open_d  = 1'b1;
          end else begin
            state_d = DENY;
            deny_d  = 1'b1;
          end
        end
      end
      OPEN: begin
        // A pass on the final open cycle still counts the car.
        if (pass) begin
          state_d     = IDLE;
          timer_d     = '0;
          pulse_std_d = ~uni_q;
          pulse_uni_d = uni_q;
        end else if (timer_q == OPEN_LAST) begin
          state_d   = IDLE;
          timer_d   = '0;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
          open_d  = 1'b1;
        end
      end
      DENY: begin
        if (timer_q == DENY_LAST) begin
          state_d = IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
          deny_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

endmodule

// File: rtl/parking_gate_controller.sv
// Entry and exit barrier control for the car park; emits clean per-car ci/uci/ce/uce pulses.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : sensors, Parking vacancy flags/counts in; pulses, barrier and status out
module parking_gate_controller
  import parking_pkg::*;
#(
  parameter int unsigned OPEN_TIMEOUT = DEF_OPEN_TIMEOUT,
  parameter int unsigned DENY_CYCLES  = DEF_DENY_CYCLES,
  parameter int unsigned COUNT_W      = DEF_COUNT_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  parking_gate_controller_if.slave  bus
);

  logic [COUNT_W-1:0] pc_c;
  logic [COUNT_W-1:0] upc_c;
  logic               ex_grant_std_c;
  logic               ex_grant_uni_c;
  gate_out_t          in_o;
  gate_out_t          ex_o;

  assign pc_c  = bus.pc;
  assign upc_c = bus.upc;

  // Exits are only granted when a car of that type is recorded inside.
  assign ex_grant_std_c = (pc_c  != '0);
  assign ex_grant_uni_c = (upc_c != '0);

  parking_gate_fsm #(
    .OPEN_TIMEOUT (OPEN_TIMEOUT),
    .DENY_CYCLES  (DENY_CYCLES)
  ) u_entry (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (bus.arrive),
    .req_uni   (bus.arrive_uni),
    .grant_std (bus.ivs),
    .grant_uni (bus.uivs),
    .pass      (bus.pass_in),
    .pulse_std (in_o.pulse_std),
    .pulse_uni (in_o.pulse_uni),
    .open      (in_o.open),
    .deny      (in_o.deny),
    .timeout   (in_o.timeout)
  );

  parking_gate_fsm #(
    .OPEN_TIMEOUT (OPEN_TIMEOUT),
    .DENY_CYCLES  (DENY_CYCLES)
  ) u_exit (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (bus.leave),
    .req_uni   (bus.leave_uni),
    .grant_std (ex_grant_std_c),
    .grant_uni (ex_grant_uni_c),
    .pass      (bus.pass_out),
    .pulse_std (ex_o.pulse_std),
    .pulse_uni (ex_o.pulse_uni),
    .open      (ex_o.open),
    .deny      (ex_o.deny),
    .timeout   (ex_o.timeout)
  );

  assign bus.ci            = in_o.pulse_std;
  assign bus.uci           = in_o.pulse_uni;
  assign bus.gate_in_open  = in_o.open;
  assign bus.deny_in       = in_o.deny;
  assign bus.timeout_in    = in_o.timeout;
  assign bus.ce            = ex_o.pulse_std;
  assign bus.uce           = ex_o.pulse_uni;
  assign bus.gate_out_open = ex_o.open;
  assign bus.deny_out      = ex_o.deny;
  assign bus.timeout_out   = ex_o.timeout;

endmodule

// File: tb/tb_parking_gate_controller.sv
// Directed cycle-table and corner-sequence bench for parking_gate_controller.
module tb_parking_gate_controller;
  import parking_pkg::*;

  // Input bit masks: {arrive, arrive_uni, pass_in, leave, leave_uni, pass_out, ivs, uivs}
  localparam logic [7:0] I_ARR  = 8'h80;
  localparam logic [7:0] I_AU   = 8'h40;
  localparam logic [7:0] I_PIN  = 8'h20;
  localparam logic [7:0] I_LV   = 8'h10;
  localparam logic [7:0] I_LU   = 8'h08;
  localparam logic [7:0] I_POUT = 8'h04;
  localparam logic [7:0] I_IVS  = 8'h02;
  localparam logic [7:0] I_UIVS = 8'h01;
  localparam logic [7:0] I_NONE = 8'h00;

  // Output masks: {ci, uci, ce, uce, gin, gout, din, dout, tin, tout}
  localparam logic [9:0] E_CI   = 10'b10_0000_0000;
  localparam logic [9:0] E_UCI  = 10'b01_0000_0000;
  localparam logic [9:0] E_CE   = 10'b00_1000_0000;
  localparam logic [9:0] E_UCE  = 10'b00_0100_0000;
  localparam logic [9:0] E_GIN  = 10'b00_0010_0000;
  localparam logic [9:0] E_GOUT = 10'b00_0001_0000;
  localparam logic [9:0] E_DIN  = 10'b00_0000_1000;
  localparam logic [9:0] E_DOUT = 10'b00_0000_0100;
  localparam logic [9:0] E_TIN  = 10'b00_0000_0010;
  localparam logic [9:0] E_TOUT = 10'b00_0000_0001;
  localparam logic [9:0] E_NONE = 10'b00_0000_0000;

  typedef struct {
    logic [7:0]  in;
    logic [10:0] pc;
    logic [10:0] upc;
    logic [9:0]  exp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  vec_t vecs[$];

  parking_gate_controller_if #(.COUNT_W(11)) bus ();

  parking_gate_controller #(
    .OPEN_TIMEOUT (20),
    .DENY_CYCLES  (4),
    .COUNT_W      (11)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] outs();
    return {bus.ci, bus.uci, bus.ce, bus.uce, bus.gate_in_open, bus.gate_out_open,
            bus.deny_in, bus.deny_out, bus.timeout_in, bus.timeout_out};
  endfunction

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b (ci uci ce uce gin gout din dout tin tout)",
               name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply(input logic [7:0] in, input logic [10:0] pc, input logic [10:0] upc);
    bus.arrive     = in[7];
    bus.arrive_uni = in[6];
    bus.pass_in    = in[5];
    bus.leave      = in[4];
    bus.leave_uni  = in[3];
    bus.pass_out   = in[2];
    bus.ivs        = in[1];
    bus.uivs       = in[0];
    bus.pc         = pc;
    bus.upc        = upc;
  endtask

  task automatic add(input logic [7:0] in, input int pc, input int upc, input logic [9:0] exp);
    vec_t v;
    v.in  = in;
    v.pc  = 11'(pc);
    v.upc = 11'(upc);
    v.exp = exp;
    vecs.push_back(v);
  endtask

  // Admit then run to timeout on one side; gate open exactly 20 cycles, then one timeout pulse.
  task automatic run_timeout(input bit exit_side);
    logic [9:0] e_open;
    logic [9:0] e_to;
    e_open = exit_side ? E_GOUT : E_GIN;
    e_to   = exit_side ? E_TOUT : E_TIN;
    if (exit_side) apply(I_LV, 11'd1, 11'd0);
    else           apply(I_ARR | I_IVS, 11'd0, 11'd0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) apply(I_NONE, 11'd1, 11'd0);
      check(exit_side ? "to_out_open" : "to_in_open", outs(), e_open);
    end
    @(negedge clk);
    check(exit_side ? "to_out_pulse" : "to_in_pulse", outs(), e_to);
    @(negedge clk);
    check(exit_side ? "to_out_after" : "to_in_after", outs(), E_NONE);
  endtask

  initial begin
    int ci_cnt;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    apply(I_NONE, 11'd0, 11'd0);

    // Cycle table: inputs set before an edge, outputs compared after it.
    add(I_ARR | I_IVS,           0, 0, E_GIN);   // public admit
    add(I_IVS,                   0, 0, E_GIN);
    add(I_IVS,                   0, 0, E_GIN);
    add(I_IVS,                   0, 0, E_GIN);
    add(I_PIN | I_IVS,           0, 0, E_CI);
    add(I_NONE,                  0, 0, E_NONE);
    add(I_ARR | I_AU | I_IVS,    0, 0, E_DIN);   // uni denied, held request
    add(I_ARR | I_AU | I_IVS,    0, 0, E_DIN);
    add(I_ARR | I_AU | I_IVS,    0, 0, E_DIN);
    add(I_ARR | I_AU | I_UIVS,   0, 0, E_DIN);
    add(I_ARR | I_AU | I_UIVS,   0, 0, E_NONE);  // back in IDLE
    add(I_ARR | I_AU | I_UIVS,   0, 0, E_GIN);   // retry granted
    add(I_PIN | I_UIVS,          0, 0, E_UCI);
    add(I_NONE,                  0, 0, E_NONE);
    add(I_LV,                    0, 7, E_DOUT);  // phantom public exit
    add(I_NONE,                  0, 7, E_DOUT);
    add(I_NONE,                  0, 7, E_DOUT);
    add(I_NONE,                  0, 7, E_DOUT);
    add(I_NONE,                  0, 7, E_NONE);
    add(I_LV,                    5, 0, E_GOUT);  // real public exit
    add(I_POUT,                  5, 0, E_CE);
    add(I_POUT,                  5, 0, E_NONE);  // pass ignored in IDLE
    add(I_LV | I_LU,             5, 0, E_DOUT);  // phantom uni exit
    add(I_NONE,                  5, 0, E_DOUT);
    add(I_NONE,                  5, 0, E_DOUT);
    add(I_NONE,                  5, 0, E_DOUT);
    add(I_NONE,                  5, 0, E_NONE);
    add(I_ARR | I_AU | I_UIVS | I_LV, 3, 0, E_GIN | E_GOUT);
    add(I_PIN | I_POUT,          3, 0, E_UCI | E_CE);   // coincident pulses
    add(I_NONE,                  3, 0, E_NONE);
    add(I_ARR | I_IVS,           0, 0, E_GIN);   // vacancy drops while open
    add(I_NONE,                  0, 0, E_GIN);
    add(I_PIN,                   0, 0, E_CI);
    add(I_LV | I_LU,             0, 2, E_GOUT);  // uni exit
    add(I_POUT,                  0, 2, E_UCE);
    add(I_NONE,                  0, 2, E_NONE);
    add(I_ARR | I_UIVS,          0, 0, E_DIN);   // public with only uni vacancy
    add(I_NONE,                  0, 0, E_DIN);
    add(I_NONE,                  0, 0, E_DIN);
    add(I_NONE,                  0, 0, E_DIN);
    add(I_NONE,                  0, 0, E_NONE);

    repeat (3) @(negedge clk);
    check("reset_held", outs(), E_NONE);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_release", outs(), E_NONE);

    foreach (vecs[i]) begin
      apply(vecs[i].in, vecs[i].pc, vecs[i].upc);
      @(negedge clk);
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end
    apply(I_NONE, 11'd0, 11'd0);
    @(negedge clk);

    run_timeout(1'b0);
    run_timeout(1'b1);

    // Pass arriving on the last open cycle beats the timeout.
    apply(I_ARR | I_IVS, 11'd0, 11'd0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) apply(I_NONE, 11'd0, 11'd0);
      check("late_open", outs(), E_GIN);
    end
    apply(I_PIN, 11'd0, 11'd0);
    @(negedge clk);
    check("late_pass", outs(), E_CI);
    apply(I_NONE, 11'd0, 11'd0);
    @(negedge clk);

    // Held pass_in gives a single ci.
    apply(I_ARR | I_IVS, 11'd0, 11'd0);
    @(negedge clk);
    check("held_open", outs(), E_GIN);
    apply(I_PIN, 11'd0, 11'd0);
    ci_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.ci) ci_cnt++;
    end
    check_int("held_ci_count", ci_cnt, 1);
    apply(I_NONE, 11'd0, 11'd0);
    @(negedge clk);

    // Reset while open aborts with no pulse.
    apply(I_ARR | I_IVS, 11'd0, 11'd0);
    @(negedge clk);
    check("abort_open", outs(), E_GIN);
    apply(I_NONE, 11'd0, 11'd0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("abort_async", outs(), E_NONE);
    @(negedge clk);
    rst_n = 1'b1;
    apply(I_PIN, 11'd0, 11'd0);
    @(negedge clk);
    check("abort_no_pulse", outs(), E_NONE);
    apply(I_NONE, 11'd0, 11'd0);
    @(negedge clk);
    check("abort_idle", outs(), E_NONE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/parking_gate_controller.md
# parking_gate_controller

Drives the entry and exit barriers of the car park and produces the single-cycle `ci`/`uci`/`ce`/`uce` event pulses consumed by `Parking`. It reads back `Parking`'s vacancy flags (`ivs`, `uivs`) and occupancy counts (`pc`, `upc`) to decide whether to admit an arriving car or release a leaving one. It sits between the gate sensors and `Parking`, so `Parking` only ever sees clean, one-cycle, per-car events.

## Interface
- `OPEN_TIMEOUT`, 20: cycles a gate stays open waiting for the car to pass.
- `DENY_CYCLES`, 4: cycles a denial indication is held.
- `COUNT_W`, 11: width of the `pc`/`upc` occupancy inputs.

- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `arrive` in 1: level; a car is waiting at the entry.
- `arrive_uni` in 1: type of the arriving car; 1 = university, 0 = public. Sampled with `arrive`.
- `pass_in` in 1: entry beam broken; the car has passed.
- `leave` in 1: level; a car is waiting at the exit.
- `leave_uni` in 1: type of the leaving car; 1 = university, 0 = public.
- `pass_out` in 1: exit beam broken.
- `ivs`, `uivs` in 1: vacancy flags from `Parking`.
- `pc`, `upc` in COUNT_W: occupancy counts from `Parking`.
- `ci`, `uci` out 1: one-cycle entry pulses to `Parking`.
- `ce`, `uce` out 1: one-cycle exit pulses to `Parking`.
- `gate_in_open`, `gate_out_open` out 1: barrier drive.
- `deny_in`, `deny_out` out 1: held for `DENY_CYCLES`.
- `timeout_in`, `timeout_out` out 1: one-cycle pulse when a gate closes without a pass.

## Operation
- Two independent instances of the same FSM: one for entry, one for exit. States are `IDLE`, `OPEN`, `DENY`.
- **IDLE, entry side.**
  - Condition: `arrive` = 1.
  - Grant is `arrive_uni ? uivs : ivs`.
  - Grant → `OPEN`, and the car type is latched. No grant → `DENY`.
- **IDLE, exit side.**
  - Condition: `leave` = 1.
  - Grant is `leave_uni ? (upc != 0) : (pc != 0)`. This rejects phantom exits.
- **OPEN.**
  - Gate output is high and the timer counts up from 0.
  - `pass_*` = 1 → pulse fires for the latched type (`ci` or `uci`; `ce` or `uce`), then → `IDLE`.
  - Timer reaches `OPEN_TIMEOUT-1` with no pass → `timeout_*` pulse, then → `IDLE`, with no count pulse.
  - `pass_*` wins if it arrives on the timeout cycle.
- **DENY.**
  - `deny_*` is high for `DENY_CYCLES` cycles, then → `IDLE`.
  - If the request is still present in `IDLE`, it is re-evaluated (this is the retry path).
- Requests are ignored outside `IDLE`. `pass_*` is ignored outside `OPEN`.
- The admission decision is final: if `ivs`/`uivs` drops while `OPEN` (for example, university capacity changes), the pulse still fires on pass.
- Entry and exit pulses may coincide in the same cycle. Both are issued.
- All outputs are registered.
- Reset value of every output is 0, and both FSMs reset to `IDLE` with timers at 0. Reset asserted mid-`OPEN` aborts the cycle with no pulse.

## Timing
- Request sampled high in `IDLE` at edge N:
  - Granted: `gate_*_open` = 1 from cycle N+1.
  - Denied: `deny_*` = 1 for cycles N+1 … N+`DENY_CYCLES`. The next evaluation happens at edge N+`DENY_CYCLES`+1.
- `pass_*` sampled at edge M while `OPEN`: the count pulse is high during cycle M+1 only, and `gate_*_open` is 0 from M+1.
- No pass: the gate is open for exactly `OPEN_TIMEOUT` cycles, and `timeout_*` is high during the first closed cycle.
- Minimum spacing between consecutive pulses on one gate is 2 cycles: `IDLE` → `OPEN` → pass.
- A held `ci` level never repeats. Exactly one pulse is issued per `OPEN` visit.

## Structure
- Shared package `parking_pkg`:
  - `gate_state_t` enum `{IDLE, OPEN, DENY}`.
  - `COUNT_W` default.
  - Default timing constants.
- Sub-module `parking_gate_fsm`, instantiated twice.
  - Inputs: `req`, `req_uni`, `grant_std`, `grant_uni`, `pass`.
  - Outputs: `pulse_std`, `pulse_uni`, `open`, `deny`, `timeout`.
  - Parameters: `OPEN_TIMEOUT`, `DENY_CYCLES`.
- Top level only forms the grant terms and maps the instance outputs to ports.

## Test plan
- **Reset.** `rst_n` = 0 for 3 cycles, then release → all outputs 0 and both FSMs in `IDLE`.
- **Public admit.** `arrive` = 1, `arrive_uni` = 0, `ivs` = 1 at edge 10; `pass_in` at edge 14 → `gate_in_open` high cycles 11–14; `ci` high only in cycle 15; `uci` stays 0.
- **University deny, then retry.** `arrive` = 1, `arrive_uni` = 1, `uivs` = 0 at edge 10 → `deny_in` high cycles 11–14. Set `uivs` = 1 at edge 13, keep `arrive` held → re-evaluated at edge 15; gate opens at cycle 16.
- **Timeout.** Admit at edge 20 with no `pass_in` → gate open cycles 21–40; `timeout_in` in cycle 41; no `ci`/`uci` pulse.
- **Phantom exit.** `leave` = 1, `leave_uni` = 0, `pc` = 0 → `deny_out` for 4 cycles, no `ce`. Same with `pc` = 5 → gate opens; `pass_out` gives one `ce` pulse.
- **Simultaneous events.** `pass_in` and `pass_out` at the same edge with `uni` entry and public exit → `uci` and `ce` both high in the next cycle. Separately, hold `pass_in` high for 10 cycles → exactly one `ci` pulse.
